muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port req_valid  input  1  operation offered.
REQ-005 SHALL have port req_ready  output  1  unit can accept.
REQ-006 SHALL have port req_op  input  muldivOp_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 SHALL have ports src_a, src_b  input  WIDTH  rs1 and rs2 operands.
REQ-008 SHALL have port flush  input  1  abort the in-flight operation.
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  RISC-V M-extension result.
REQ-012 SHALL have port resp_illegal  output  1  operation not supported in this build.

Function
REQ-013 SHALL implement the states IDLE, CALC, FIXUP and DONE.
REQ-014 SHALL drive req_ready=1 only in IDLE.
REQ-015 SHALL capture the operation on a handshake in cycle T: operands stored as magnitudes plus sign flags per op signedness; MULHSU treats only src_a as signed.
REQ-016 SHALL, in CALC, perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle using a 6-bit iteration counter, for exactly WIDTH cycles (T+1..T+WIDTH).
REQ-017 SHALL, in FIXUP (T+WIDTH+1), negate the product, quotient or remainder as required, and select the low or high word (MUL selects low; MULH* select high).
REQ-018 SHALL assert resp_valid in DONE from cycle T+WIDTH+2, holding result stable until resp_valid&&resp_ready, then return to IDLE.
REQ-019 SHALL treat divide-by-zero as a short-circuit: IDLE->DONE, resp_valid at T+1, quotient all-ones, remainder = src_a.
REQ-020 SHALL treat signed overflow (DIV/REM, src_a=most-negative, src_b=-1) as a short-circuit: quotient = src_a, remainder 0, resp_valid at T+1.
REQ-021 SHALL give remainder the sign of the dividend and quotient sign = sign_a XOR sign_b.
REQ-022 SHALL, on flush in CALC or FIXUP, go to IDLE next cycle with no resp_valid; flush in DONE SHALL drop the result; flush in IDLE SHALL be ignored, and a simultaneous req is not accepted.
REQ-023 SHALL take no new request before the previous response handshake, so no back-to-back overlap is possible.
REQ-024 SHALL drive result=0 whenever resp_valid=0.

Reset
REQ-025 SHALL, on rst assertion, immediately force IDLE, req_ready=1 after release, resp_valid=0, result=0, resp_illegal=0, and counter=0, including mid-CALC.
REQ-026 SHALL leave no partial result visible after reset.

Configuration
REQ-027 SHALL use the macro MULDIV_DIV_EN: when defined, the divide datapath is included, with resp_illegal constant 0.
REQ-028 SHALL, without MULDIV_DIV_EN, omit the divide datapath; DIV/DIVU/REM/REMU short-circuit to DONE at T+1 with result 0 and resp_illegal=1, and multiplies are unchanged.

Structure
REQ-029 SHALL declare muldivOp_t and the state enum in the shared core package, alongside the adder and shifter op typedefs.
REQ-030 SHALL contain one combinational sub-module, muldiv_step, computing a single WIDTH+1-bit add-or-subtract-and-shift iteration; the sequencer owns all registers.

Verification
REQ-031 SHALL verify MUL 7 x -3 -> result 0xFFFFFFEB, resp_valid at T+34.
REQ-032 SHALL verify MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 SHALL verify DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-034 SHALL verify DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 0x80000000/-1 -> 0 at T+1.
REQ-035 SHALL verify flush at T+10 -> resp_valid never asserts and req_ready=1 at T+11; rst at T+5 -> IDLE, resp_valid=0.
REQ-036 SHALL verify resp_ready held low 5 cycles -> result stable, req_ready=0 throughout; without MULDIV_DIV_EN, DIV -> resp_illegal=1, result 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared core package for the sequential multiply/divide unit.
// Holds the operation, sequencer state and step-datapath control types,
// plus small decode helpers used by the sequencer.
package muldiv_pkg;

    // RISC-V M-extension operations, encoded in funct3 order
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldivOp_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_t;

    // Adder operation of one iteration step
    typedef enum logic {
        STEP_ADD = 1'b0,
        STEP_SUB = 1'b1
    } step_add_op_t;

    // Shift direction of one iteration step
    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } step_shift_op_t;

    function automatic logic is_div_op(input muldivOp_t op);
        return op[2];
    endfunction

    function automatic logic is_rem_op(input muldivOp_t op);
        return (op == REM) || (op == REMU);
    endfunction

    // rs1 is treated as signed for these operations
    function automatic logic op_signed_a(input muldivOp_t op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed for these operations
    function automatic logic op_signed_b(input muldivOp_t op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
// Multiply: conditional add of the multiplicand on the multiplier LSB, then
// shift the {acc, lo} pair right. Divide: shift {acc, lo} left, trial
// subtract the divisor (restoring), quotient bit enters lo from the right.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_add_op_t   add_op,
    input  step_shift_op_t shift_op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] work;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] kept;
    logic           take;

    // Single WIDTH+1-bit add-or-subtract followed by the shift
    always_comb begin
        work = (shift_op == SHIFT_LEFT) ? {acc, lo[WIDTH-1]} : {1'b0, acc};
        sum  = work;
        take = 1'b0;
        case (add_op)
            STEP_ADD: begin
                take = lo[0];
                sum  = work + {1'b0, operand};
            end
            STEP_SUB: begin
                take = (work >= {1'b0, operand});
                sum  = {1'b0, work[WIDTH-1:0] - operand};
            end
            default: begin
                take = 1'b0;
                sum  = work;
            end
        endcase
        kept = take ? sum : work;
        if (shift_op == SHIFT_LEFT) begin
            acc_next = kept[WIDTH-1:0];
            lo_next  = {lo[WIDTH-2:0], take};
        end else begin
            acc_next = kept[WIDTH:1];
            lo_next  = {kept[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension multiply/divide unit.
// One iteration per cycle for WIDTH cycles, then a sign/word fixup cycle.
// Divide-by-zero and signed overflow bypass the iteration entirely.
// Build option: define MULDIV_DIV_EN to include the divide datapath; without
// it divide operations complete immediately with resp_illegal set.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  muldivOp_t        req_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             resp_illegal
);

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    muldiv_state_t    state_q, state_d;
    logic [5:0]       count_q;
    logic [WIDTH-1:0] acc_q, lo_q, opnd_q, res_q;
    muldivOp_t        op_q;
    logic             neg_q;
`ifndef MULDIV_DIV_EN
    logic             ill_q;
    logic             sc_ill;
`endif

    logic             accept;
    logic             sign_a, sign_b, neg_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sc_hit;
    logic [WIDTH-1:0] sc_res;

    step_add_op_t     step_add;
    step_shift_op_t   step_shift;
    logic [WIDTH-1:0] step_acc, step_lo;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_res;

    // A request is taken only in IDLE and never alongside a flush
    assign accept = req_valid && (state_q == IDLE) && !flush;

    // Split the incoming operands into magnitudes and sign flags
    always_comb begin
        sign_a = op_signed_a(req_op) && src_a[WIDTH-1];
        sign_b = op_signed_b(req_op) && src_b[WIDTH-1];
        mag_a  = sign_a ? (~src_a + 1'b1) : src_a;
        mag_b  = sign_b ? (~src_b + 1'b1) : src_b;
        neg_in = is_rem_op(req_op) ? sign_a : (sign_a ^ sign_b);
    end

    // Detect operations that finish without iterating and their results
    always_comb begin
        sc_hit = 1'b0;
        sc_res = '0;
`ifdef MULDIV_DIV_EN
        if (is_div_op(req_op)) begin
            if (src_b == '0) begin
                sc_hit = 1'b1;
                sc_res = is_rem_op(req_op) ? src_a : '1;
            end else if (op_signed_b(req_op) && (src_a == MOST_NEG) && (src_b == '1)) begin
                sc_hit = 1'b1;
                sc_res = is_rem_op(req_op) ? '0 : src_a;
            end
        end
`else
        sc_ill = 1'b0;
        if (is_div_op(req_op)) begin
            sc_hit = 1'b1;
            sc_ill = 1'b1;
        end
`endif
    end

`ifdef MULDIV_DIV_EN
    assign step_add   = is_div_op(op_q) ? STEP_SUB : STEP_ADD;
    assign step_shift = is_div_op(op_q) ? SHIFT_LEFT : SHIFT_RIGHT;
`else
    assign step_add   = STEP_ADD;
    assign step_shift = SHIFT_RIGHT;
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .add_op   (step_add),
        .shift_op (step_shift),
        .acc      (acc_q),
        .lo       (lo_q),
        .operand  (opnd_q),
        .acc_next (step_acc),
        .lo_next  (step_lo)
    );

    // Apply the result sign and pick the requested word
    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        fix_res  = '0;
        case (op_q)
            MUL:                  fix_res = prod_fix[WIDTH-1:0];
            MULH, MULHSU, MULHU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
            DIV, DIVU:            fix_res = neg_q ? (~lo_q + 1'b1) : lo_q;
            REM, REMU:            fix_res = neg_q ? (~acc_q + 1'b1) : acc_q;
`endif
            default:              fix_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_d = sc_hit ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (count_q == LAST_STEP) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = flush ? IDLE : DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            op_q    <= MUL;
            neg_q   <= 1'b0;
`ifndef MULDIV_DIV_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        neg_q   <= neg_in;
                        acc_q   <= '0;
                        lo_q    <= mag_a;
                        opnd_q  <= mag_b;
                        count_q <= '0;
                        res_q   <= sc_res;
`ifndef MULDIV_DIV_EN
                        ill_q   <= sc_ill;
`endif
                    end
                end
                CALC: begin
                    acc_q   <= step_acc;
                    lo_q    <= step_lo;
                    count_q <= (flush || (count_q == LAST_STEP)) ? 6'd0 : count_q + 6'd1;
                end
                FIXUP: begin
                    res_q <= fix_res;
                end
                DONE: begin
                    if (flush || resp_ready) begin
                        res_q <= '0;
`ifndef MULDIV_DIV_EN
                        ill_q <= 1'b0;
`endif
                    end
                end
                default: count_q <= '0;
            endcase
        end
    end

    assign result = resp_valid ? res_q : '0;
`ifdef MULDIV_DIV_EN
    assign resp_illegal = 1'b0;
`else
    assign resp_illegal = resp_valid && ill_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32).
// Expectations for divide operations follow the MULDIV_DIV_EN build option.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;
    localparam int FULL_LAT = WIDTH + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    muldivOp_t   req_op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        resp_illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        muldivOp_t   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .result       (result),
        .resp_illegal (resp_illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input muldivOp_t op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_lat = lat; v.exp_ill = 1'b0;
        return v;
    endfunction

    // Divide vectors: without the divide datapath they finish at once as illegal
    function automatic vec_t mkdiv(input muldivOp_t op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r, input int lat);
        vec_t v;
        v = mk(op, a, b, r, lat);
`ifndef MULDIV_DIV_EN
        v.exp_res = 32'd0;
        v.exp_lat = 1;
        v.exp_ill = 1'b1;
`endif
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Run one operation from an IDLE cycle through its response handshake
    task automatic applyStimulus(input muldivOp_t op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat, output logic ill);
        req_op = op; src_a = a; src_b = b; req_valid = 1'b1;
        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            total++; bad++;
            $display("[TB] FAIL resp_timeout: got no resp_valid, expected one within 100 cycles");
        end
        res = result;
        ill = resp_illegal;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        ill;
        logic        seen;

        rst = 1'b1; req_valid = 1'b0; req_op = MUL; src_a = '0; src_b = '0;
        flush = 1'b0; resp_ready = 1'b0;

        vecs.push_back(mk(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, FULL_LAT));
        vecs.push_back(mk(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT));
        vecs.push_back(mk(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, FULL_LAT));
        vecs.push_back(mk(MULH,   32'h80000000, 32'h80000000, 32'h40000000, FULL_LAT));
        vecs.push_back(mk(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, FULL_LAT));
        vecs.push_back(mk(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, FULL_LAT));
        vecs.push_back(mk(MULHU,  32'h00010000, 32'h00010000, 32'h00000001, FULL_LAT));
        vecs.push_back(mkdiv(DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, FULL_LAT));
        vecs.push_back(mkdiv(REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, FULL_LAT));
        vecs.push_back(mkdiv(DIVU, 32'd100,      32'd7,        32'd14,       FULL_LAT));
        vecs.push_back(mkdiv(REMU, 32'd100,      32'd7,        32'd2,        FULL_LAT));
        vecs.push_back(mkdiv(DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, FULL_LAT));
        vecs.push_back(mkdiv(REM,  32'd7,        32'hFFFFFFFE, 32'd1,        FULL_LAT));
        vecs.push_back(mkdiv(DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, FULL_LAT));
        vecs.push_back(mkdiv(DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1));
        vecs.push_back(mkdiv(DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1));
        vecs.push_back(mkdiv(REMU, 32'd5,        32'd0,        32'd5,        1));
        vecs.push_back(mkdiv(REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1));
        vecs.push_back(mkdiv(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_req_ready",    {31'd0, req_ready},    32'd1);
        checkOutput("reset_resp_valid",   {31'd0, resp_valid},   32'd0);
        checkOutput("reset_result",       result,                32'd0);
        checkOutput("reset_resp_illegal", {31'd0, resp_illegal}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, ill);
            checkOutput($sformatf("vec%0d_result", i),  res,                 vecs[i].exp_res);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat),            32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d_illegal", i), {31'd0, ill},        {31'd0, vecs[i].exp_ill});
        end

        // Flush at T+10 aborts the multiply; ready again at T+11
        req_op = MUL; src_a = 32'd7; src_b = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            seen |= resp_valid;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_req_ready_t11", {31'd0, req_ready}, 32'd1);
        for (int c = 0; c < 40; c++) begin
            seen |= resp_valid;
            @(posedge clk); #1;
        end
        checkOutput("flush_no_resp_valid", {31'd0, seen}, 32'd0);
        applyStimulus(MUL, 32'd7, 32'hFFFFFFFD, res, lat, ill);
        checkOutput("after_flush_result", res, 32'hFFFFFFEB);

        // Reset at T+5 in the middle of a multiply
        req_op = MULHU; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("midrst_result",     result,              32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            seen |= resp_valid;
            @(posedge clk); #1;
        end
        checkOutput("midrst_no_resp_valid", {31'd0, seen}, 32'd0);
        applyStimulus(MUL, 32'd7, 32'hFFFFFFFD, res, lat, ill);
        checkOutput("after_rst_latency", 32'(lat), 32'(FULL_LAT));

        // Response held for 5 cycles with resp_ready low
        req_op = MUL; src_a = 32'd7; src_b = 32'hFFFFFFFD; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("hold_result",     result,              32'hFFFFFFEB);
            checkOutput("hold_req_ready",  {31'd0, req_ready},  32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("hold_release_req_ready", {31'd0, req_ready},  32'd1);
        checkOutput("hold_release_result",    result,              32'd0);

        // Flush in DONE drops the pending response
        req_op = DIVU; src_a = 32'd5; src_b = 32'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("done_flush_valid_before", {31'd0, resp_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("done_flush_valid_after", {31'd0, resp_valid}, 32'd0);
        checkOutput("done_flush_req_ready",   {31'd0, req_ready},  32'd1);

        // Flush in IDLE blocks a simultaneous request
        req_op = DIVU; src_a = 32'd5; src_b = 32'd0; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        checkOutput("idle_flush_no_accept_ready", {31'd0, req_ready},  32'd1);
        checkOutput("idle_flush_no_accept_valid", {31'd0, resp_valid}, 32'd0);

`ifndef MULDIV_DIV_EN
        // Divide in a multiply-only build reports illegal with a zero result
        req_op = DIV; src_a = 32'd100; src_b = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("nodiv_resp_valid",   {31'd0, resp_valid},   32'd1);
        checkOutput("nodiv_resp_illegal", {31'd0, resp_illegal}, 32'd1);
        checkOutput("nodiv_result",       result,                32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("nodiv_illegal_cleared", {31'd0, resp_illegal}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
